// File: rtl/ascon_round_sequencer_if.sv
// Request/response bundle between the mode/control FSM (master) and the
// Ascon round sequencer (slave).
interface ascon_round_sequencer_if;
   logic         start;
   logic         round_sel;
   logic [319:0] state_in;
   logic         busy;
   logic         done;
   logic [319:0] state_out;
   logic [3:0]   rc_idx;

   modport master (
      output start, round_sel, state_in,
      input  busy, done, state_out, rc_idx
   );

   modport slave (
      input  start, round_sel, state_in,
      output busy, done, state_out, rc_idx
   );
endinterface

// File: rtl/ascon_round_sequencer.sv
// Iterative Ascon permutation: one full round (constant, S-box, diffusion) per
// clock, running p^a or p^b on a 320-bit state held in r_state.
module ascon_round_sequencer #(
   parameter int ROUNDS_PA = 12,
   parameter int ROUNDS_PB = 6
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   ascon_round_sequencer_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] IDX_PA   = 4'(12 - ROUNDS_PA);
   localparam logic [3:0] IDX_PB   = 4'(12 - ROUNDS_PB);
   localparam logic [3:0] IDX_LAST = 4'd11;

   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   generate
      if (ROUNDS_PA < 1 || ROUNDS_PA > 12) begin : g_bad_pa
         $error("ROUNDS_PA must be in 1..12");
      end
      if (ROUNDS_PB < 1 || ROUNDS_PB > 12) begin : g_bad_pb
         $error("ROUNDS_PB must be in 1..12");
      end
   endgenerate

   function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   logic [1:0]   r_fsm;
   logic         r_rst_q;
   logic         r_busy;
   logic         r_done;
   logic [319:0] r_state;
   logic [3:0]   r_rc_idx;

   logic [63:0]  w_x [5];
   logic [63:0]  w_a [5];
   logic [63:0]  w_b [5];
   logic [63:0]  w_s [5];
   logic [319:0] w_round;
   logic [3:0]   w_start_idx;

   // Constant addition folded into the S-box input stage of lane 2.
   assign w_a[0] = w_x[0] ^ w_x[4];
   assign w_a[1] = w_x[1];
   assign w_a[2] = w_x[2] ^ {56'd0, ~r_rc_idx, r_rc_idx} ^ w_x[1];
   assign w_a[3] = w_x[3];
   assign w_a[4] = w_x[4] ^ w_x[3];

   assign w_s[0] = w_b[0] ^ w_b[4];
   assign w_s[1] = w_b[1] ^ w_b[0];
   assign w_s[2] = ~w_b[2];
   assign w_s[3] = w_b[3] ^ w_b[2];
   assign w_s[4] = w_b[4];

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_lane
         assign w_x[gi] = r_state[319 - 64*gi -: 64];
         assign w_b[gi] = w_a[gi] ^ (~w_a[(gi + 1) % 5] & w_a[(gi + 2) % 5]);
         assign w_round[319 - 64*gi -: 64] =
            w_s[gi] ^ ror64(w_s[gi], ROT_A[gi]) ^ ror64(w_s[gi], ROT_B[gi]);
      end
   endgenerate

   assign w_start_idx = bus.round_sel ? IDX_PB : IDX_PA;

   // Reset asserts asynchronously but the FSM is only released one edge later,
   // so a start coinciding with reset release is never taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rst_q <= 1'b0;
      else          r_rst_q <= 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fsm    <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_state  <= '0;
         r_rc_idx <= '0;
      end else if (!r_rst_q) begin
         r_fsm    <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_state  <= '0;
         r_rc_idx <= '0;
      end else begin
         case (r_fsm)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_fsm    <= ST_RUN;
                  r_busy   <= 1'b1;
                  r_state  <= bus.state_in;
                  r_rc_idx <= w_start_idx;
               end else begin
                  r_fsm <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_state <= w_round;
               if (r_rc_idx == IDX_LAST) begin
                  r_fsm  <= ST_DONE;
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end else begin
                  r_rc_idx <= r_rc_idx + 4'd1;
               end
            end
            default: begin
               r_fsm  <= ST_IDLE;
               r_busy <= 1'b0;
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.state_out = r_state;
   assign bus.rc_idx    = r_rc_idx;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer: latency, rc_idx sequencing, back-to-back
// and ignored starts, reset abort, checked against a table-driven round model.
module tb_ascon_round_sequencer;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   ascon_round_sequencer_if bus_if ();

   ascon_round_sequencer #(
      .ROUNDS_PA (12),
      .ROUNDS_PB (6)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1);
   end

   // Ascon 5-bit S-box, input/output bit 4 = lane x0.
   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int RA [5] = '{19, 61, 1, 10, 7};
   localparam int RB [5] = '{28, 39, 6, 17, 41};

   function automatic logic [319:0] ref_round(input logic [319:0] s, input int idx);
      logic [63:0]  x [5];
      logic [63:0]  y [5];
      logic [63:0]  z [5];
      logic [4:0]   v;
      logic [4:0]   o;
      logic [7:0]   c;
      logic [319:0] r;
      for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
      c = 8'(((15 - idx) << 4) + idx);
      x[2][7:0] = x[2][7:0] ^ c;
      for (int j = 0; j < 64; j++) begin
         v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
         o = SBOX[v];
         y[0][j] = o[4]; y[1][j] = o[3]; y[2][j] = o[2]; y[3][j] = o[1]; y[4][j] = o[0];
      end
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 64; j++)
            z[i][j] = y[i][j] ^ y[i][(j + RA[i]) % 64] ^ y[i][(j + RB[i]) % 64];
      for (int i = 0; i < 5; i++) r[319 - 64*i -: 64] = z[i];
      return r;
   endfunction

   function automatic logic [319:0] ref_perm(input logic [319:0] s, input int rounds);
      logic [319:0] t;
      t = s;
      for (int k = 0; k < rounds; k++) t = ref_round(t, 12 - rounds + k);
      return t;
   endfunction

   task automatic check_val(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Status word {busy, done, rc_idx}.
   function automatic logic [5:0] status();
      return {bus_if.busy, bus_if.done, bus_if.rc_idx};
   endfunction

   task automatic do_run(input string tag, input bit sel, input logic [319:0] st,
                         input bit already, input bit glitch, input bit chain,
                         input bit nsel, input logic [319:0] nst);
      int           r;
      logic [319:0] exp;
      r   = sel ? 6 : 12;
      exp = ref_perm(st, r);
      if (!already) begin
         bus_if.start     = 1'b1;
         bus_if.round_sel = sel;
         bus_if.state_in  = st;
      end
      tick();
      bus_if.start     = 1'b0;
      bus_if.round_sel = ~sel;
      bus_if.state_in  = ~st;
      for (int k = 0; k < r; k++) begin
         check_val($sformatf("%s_run%0d", tag, k), 320'(status()),
                   320'({1'b1, 1'b0, 4'(12 - r + k)}));
         if (glitch && (k + 1 == 3 || k + 1 == 7)) begin
            bus_if.start    = 1'b1;
            bus_if.state_in = {5{64'hdeadbeef_cafef00d}};
         end else begin
            bus_if.start = 1'b0;
         end
         tick();
      end
      bus_if.start = 1'b0;
      check_val({tag, "_done"}, 320'(status()), 320'({1'b0, 1'b1, 4'd11}));
      check_val({tag, "_result"}, bus_if.state_out, exp);
      $display("run %s sel=%0d result=%h", tag, sel, bus_if.state_out);
      if (chain) begin
         bus_if.start     = 1'b1;
         bus_if.round_sel = nsel;
         bus_if.state_in  = nst;
      end else begin
         tick();
         check_val({tag, "_idle"}, 320'(status()), 320'({1'b0, 1'b0, 4'd11}));
         check_val({tag, "_hold"}, bus_if.state_out, exp);
      end
   endtask

   logic [319:0] iv_state;
   logic [319:0] pat_a;
   logic [319:0] pat_b;

   initial begin
      iv_state = {64'h80400c0600000000, 256'd0};
      pat_a    = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                  64'h8796a5b4c3d2e1f0, 64'h5555aaaa3333cccc};
      pat_b    = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
                  64'h4444444444444444, 64'h5555555555555555};
      rst_n            = 1'b1;
      bus_if.start     = 1'b0;
      bus_if.round_sel = 1'b0;
      bus_if.state_in  = '0;

      // Asynchronous reset before any clock edge.
      #3 rst_n = 1'b0;
      #1;
      check_val("reset_status", 320'(status()), 320'(6'd0));
      check_val("reset_state", bus_if.state_out, 320'd0);
      tick();
      tick();
      // Start coinciding with reset release must be ignored.
      rst_n            = 1'b1;
      bus_if.start     = 1'b1;
      bus_if.state_in  = pat_a;
      tick();
      bus_if.start = 1'b0;
      check_val("release_start_ignored", 320'(status()), 320'(6'd0));
      tick();
      check_val("release_still_idle", 320'(status()), 320'(6'd0));

      do_run("pa_zero", 1'b0, 320'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      do_run("pb_iv", 1'b1, iv_state, 1'b0, 1'b0, 1'b0, 1'b0, '0);

      do_run("b2b_first", 1'b0, pat_a, 1'b0, 1'b0, 1'b1, 1'b1, pat_b);
      do_run("b2b_second", 1'b1, pat_b, 1'b1, 1'b0, 1'b0, 1'b0, '0);

      do_run("pa_glitch", 1'b0, 320'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

      // Abort a p^a run during round 5.
      bus_if.start     = 1'b1;
      bus_if.round_sel = 1'b0;
      bus_if.state_in  = pat_a;
      tick();
      bus_if.start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check_val("abort_pre", 320'(status()), 320'({1'b1, 1'b0, 4'd4}));
      #2 rst_n = 1'b0;
      #1;
      check_val("abort_status", 320'(status()), 320'(6'd0));
      check_val("abort_state", bus_if.state_out, 320'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val($sformatf("abort_hold%0d", k), 320'(status()), 320'(6'd0));
      end
      rst_n            = 1'b1;
      bus_if.start     = 1'b1;
      bus_if.state_in  = pat_b;
      tick();
      bus_if.start = 1'b0;
      check_val("abort_release_ignored", 320'(status()), 320'(6'd0));
      tick();
      check_val("abort_no_done", 320'(status()), 320'(6'd0));
      do_run("pa_after_abort", 1'b0, pat_a, 1'b0, 1'b0, 1'b0, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
